// File: rtl/id_stage.sv
// RV32I decode stage: register file with write-through bypass, instruction decode,
// load-use hazard detection and the ID/EX pipeline register. Optional: ID_ILLEGAL_TRAP_EN.
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_id,
  input  logic [29:0] pc_id,
  input  logic        stall,
  input  logic        rst_pipe,
  input  logic        jmp_flush_ex,
  input  logic        post_jump_cmd_cond,
  input  logic        wbk_en,
  input  logic [4:0]  wbk_rd_adr,
  input  logic [31:0] wbk_data,
  output logic [31:0] inst_ex,
  output logic [29:0] pc_ex,
  output logic        valid_ex,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [31:0] imm_ex,
  output logic [4:0]  rd_adr_ex,
  output logic [4:0]  rs1_adr_ex,
  output logic [4:0]  rs2_adr_ex,
  output logic [2:0]  funct3_ex,
  output logic        funct7b5_ex,
  output logic        cmd_lui_ex,
  output logic        cmd_auipc_ex,
  output logic        cmd_jal_ex,
  output logic        cmd_jalr_ex,
  output logic        cmd_br_ex,
  output logic        cmd_ld_ex,
  output logic        cmd_st_ex,
  output logic        cmd_alui_ex,
  output logic        cmd_alu_ex,
  output logic        cmd_sys_ex,
  output logic        wbk_en_ex,
  output logic        stall_ld,
  output logic        stall_ld_ex
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_ex
`endif
);

  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_BR    = 5'b11000;
  localparam logic [4:0] OPC_LD    = 5'b00000;
  localparam logic [4:0] OPC_ST    = 5'b01000;
  localparam logic [4:0] OPC_ALUI  = 5'b00100;
  localparam logic [4:0] OPC_ALU   = 5'b01100;
  localparam logic [4:0] OPC_SYS   = 5'b11100;

  typedef struct packed {
    logic [31:0] inst;
    logic [29:0] pc;
    logic        valid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        cmd_lui;
    logic        cmd_auipc;
    logic        cmd_jal;
    logic        cmd_jalr;
    logic        cmd_br;
    logic        cmd_ld;
    logic        cmd_st;
    logic        cmd_alui;
    logic        cmd_alu;
    logic        cmd_sys;
    logic        wbk_en;
  } ex_reg_t;

  function automatic ex_reg_t bubble(input logic [29:0] pc);
    ex_reg_t b;
    b      = '0;
    b.inst = NOP_INST;
    b.pc   = pc;
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] rf [0:31];
  logic [4:0]  rs1_adr;
  logic [4:0]  rs2_adr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  assign rs1_adr = inst_id[19:15];
  assign rs2_adr = inst_id[24:20];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering. The register file is cleared
  // on reset because software may read registers before writing them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wbk_en && wbk_rd_adr != 5'd0) begin
      rf[wbk_rd_adr] <= wbk_data;
    end
  end

  // Write-through lets an instruction see a result being written this cycle.
  assign rs1_data = (rs1_adr == 5'd0) ? 32'd0 :
                    (wbk_en && wbk_rd_adr == rs1_adr) ? wbk_data : rf[rs1_adr];
  assign rs2_data = (rs2_adr == 5'd0) ? 32'd0 :
                    (wbk_en && wbk_rd_adr == rs2_adr) ? wbk_data : rf[rs2_adr];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  ex_reg_t dec;
  logic    use_rs1;
  logic    use_rs2;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    dec          = '0;
    dec.inst     = inst_id;
    dec.pc       = pc_id;
    dec.valid    = 1'b1;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.rd       = inst_id[11:7];
    dec.rs1      = rs1_adr;
    dec.rs2      = rs2_adr;
    dec.funct3   = inst_id[14:12];
    dec.funct7b5 = inst_id[30];
    case (inst_id[6:2])
      OPC_LUI:   dec.cmd_lui   = 1'b1;
      OPC_AUIPC: dec.cmd_auipc = 1'b1;
      OPC_JAL:   dec.cmd_jal   = 1'b1;
      OPC_JALR:  dec.cmd_jalr  = 1'b1;
      OPC_BR:    dec.cmd_br    = 1'b1;
      OPC_LD:    dec.cmd_ld    = 1'b1;
      OPC_ST:    dec.cmd_st    = 1'b1;
      OPC_ALUI:  dec.cmd_alui  = 1'b1;
      OPC_ALU:   dec.cmd_alu   = 1'b1;
      OPC_SYS:   dec.cmd_sys   = 1'b1;
      default: ;
    endcase

    if (dec.cmd_ld || dec.cmd_alui || dec.cmd_jalr || dec.cmd_sys)
      dec.imm = {{20{inst_id[31]}}, inst_id[31:20]};
    else if (dec.cmd_st)
      dec.imm = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
    else if (dec.cmd_br)
      dec.imm = {{19{inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25],
                 inst_id[11:8], 1'b0};
    else if (dec.cmd_lui || dec.cmd_auipc)
      dec.imm = {inst_id[31:12], 12'd0};
    else if (dec.cmd_jal)
      dec.imm = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12], inst_id[20],
                 inst_id[30:21], 1'b0};

    dec.wbk_en = (dec.rd != 5'd0) &&
                 (dec.cmd_lui || dec.cmd_auipc || dec.cmd_jal || dec.cmd_jalr ||
                  dec.cmd_ld || dec.cmd_alui || dec.cmd_alu);
  end

  assign use_rs1 = dec.cmd_jalr | dec.cmd_br | dec.cmd_ld | dec.cmd_st |
                   dec.cmd_alui | dec.cmd_alu;
  assign use_rs2 = dec.cmd_br | dec.cmd_st | dec.cmd_alu;

  // ---------------------------------------------------------------------------
  // Load-use hazard and EX pipeline register
  // ---------------------------------------------------------------------------
  ex_reg_t ex_q;
  ex_reg_t ex_d;
  logic    ex_bubble;
  logic    ex_load;

  // A taken jump discards the ID instruction anyway, so it never needs to wait.
  assign stall_ld = ex_q.valid & ex_q.cmd_ld & (ex_q.rd != 5'd0) &
                    ((use_rs1 & (rs1_adr == ex_q.rd)) |
                     (use_rs2 & (rs2_adr == ex_q.rd))) &
                    ~jmp_flush_ex;

  assign ex_bubble = rst_pipe |
                     (~stall & (jmp_flush_ex | post_jump_cmd_cond | stall_ld));
  assign ex_load   = ~rst_pipe & ~stall &
                     ~(jmp_flush_ex | post_jump_cmd_cond | stall_ld);

  always_comb begin
    ex_d = ex_q;
    if (ex_bubble)    ex_d = bubble(pc_id);
    else if (ex_load) ex_d = dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= bubble(30'd0);
      stall_ld_ex <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      stall_ld_ex <= stall_ld & ~rst_pipe;
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  logic       ill_dec;
  logic [6:0] funct7;

  assign funct7 = inst_id[31:25];

  always_comb begin
    ill_dec = (inst_id[1:0] != 2'b11) ||
              !(dec.cmd_lui || dec.cmd_auipc || dec.cmd_jal || dec.cmd_jalr ||
                dec.cmd_br || dec.cmd_ld || dec.cmd_st || dec.cmd_alui ||
                dec.cmd_alu || dec.cmd_sys);
    if (dec.cmd_alu && funct7 != 7'h00 && funct7 != 7'h20)
      ill_dec = 1'b1;
    // funct7=0x20 only qualifies SUB and SRA/SRAI.
    if ((dec.cmd_alu || dec.cmd_alui) && funct7 == 7'h20 &&
        !(dec.funct3 == 3'b101 || (dec.cmd_alu && dec.funct3 == 3'b000)))
      ill_dec = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       illegal_ex <= 1'b0;
    else if (ex_bubble) illegal_ex <= 1'b0;
    else if (ex_load)   illegal_ex <= ill_dec;
  end
`endif

  assign inst_ex      = ex_q.inst;
  assign pc_ex        = ex_q.pc;
  assign valid_ex     = ex_q.valid;
  assign rs1_data_ex  = ex_q.rs1_data;
  assign rs2_data_ex  = ex_q.rs2_data;
  assign imm_ex       = ex_q.imm;
  assign rd_adr_ex    = ex_q.rd;
  assign rs1_adr_ex   = ex_q.rs1;
  assign rs2_adr_ex   = ex_q.rs2;
  assign funct3_ex    = ex_q.funct3;
  assign funct7b5_ex  = ex_q.funct7b5;
  assign cmd_lui_ex   = ex_q.cmd_lui;
  assign cmd_auipc_ex = ex_q.cmd_auipc;
  assign cmd_jal_ex   = ex_q.cmd_jal;
  assign cmd_jalr_ex  = ex_q.cmd_jalr;
  assign cmd_br_ex    = ex_q.cmd_br;
  assign cmd_ld_ex    = ex_q.cmd_ld;
  assign cmd_st_ex    = ex_q.cmd_st;
  assign cmd_alui_ex  = ex_q.cmd_alui;
  assign cmd_alu_ex   = ex_q.cmd_alu;
  assign cmd_sys_ex   = ex_q.cmd_sys;
  assign wbk_en_ex    = ex_q.wbk_en;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases plus randomized traffic
// compared against a behavioural model of the decode stage.
module tb_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int C_LUI = 0, C_AUIPC = 1, C_JAL = 2, C_JALR = 3, C_BR = 4;
  localparam int C_LD = 5, C_ST = 6, C_ALUI = 7, C_ALU = 8, C_SYS = 9, C_NONE = 10;

  logic        clk, rst_n;
  logic [31:0] inst_id;
  logic [29:0] pc_id;
  logic        stall, rst_pipe, jmp_flush_ex, post_jump_cmd_cond;
  logic        wbk_en;
  logic [4:0]  wbk_rd_adr;
  logic [31:0] wbk_data;
  logic [31:0] inst_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [29:0] pc_ex;
  logic        valid_ex;
  logic [4:0]  rd_adr_ex, rs1_adr_ex, rs2_adr_ex;
  logic [2:0]  funct3_ex;
  logic        funct7b5_ex;
  logic        cmd_lui_ex, cmd_auipc_ex, cmd_jal_ex, cmd_jalr_ex, cmd_br_ex;
  logic        cmd_ld_ex, cmd_st_ex, cmd_alui_ex, cmd_alu_ex, cmd_sys_ex;
  logic        wbk_en_ex, stall_ld, stall_ld_ex;
`ifdef ID_ILLEGAL_TRAP_EN
  logic        illegal_ex;
`endif

  int checks   = 0;
  int failures = 0;

  id_stage #(.NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .pc_id(pc_id),
    .stall(stall), .rst_pipe(rst_pipe), .jmp_flush_ex(jmp_flush_ex),
    .post_jump_cmd_cond(post_jump_cmd_cond), .wbk_en(wbk_en),
    .wbk_rd_adr(wbk_rd_adr), .wbk_data(wbk_data), .inst_ex(inst_ex),
    .pc_ex(pc_ex), .valid_ex(valid_ex), .rs1_data_ex(rs1_data_ex),
    .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rd_adr_ex(rd_adr_ex),
    .rs1_adr_ex(rs1_adr_ex), .rs2_adr_ex(rs2_adr_ex), .funct3_ex(funct3_ex),
    .funct7b5_ex(funct7b5_ex), .cmd_lui_ex(cmd_lui_ex), .cmd_auipc_ex(cmd_auipc_ex),
    .cmd_jal_ex(cmd_jal_ex), .cmd_jalr_ex(cmd_jalr_ex), .cmd_br_ex(cmd_br_ex),
    .cmd_ld_ex(cmd_ld_ex), .cmd_st_ex(cmd_st_ex), .cmd_alui_ex(cmd_alui_ex),
    .cmd_alu_ex(cmd_alu_ex), .cmd_sys_ex(cmd_sys_ex), .wbk_en_ex(wbk_en_ex),
    .stall_ld(stall_ld), .stall_ld_ex(stall_ld_ex)
`ifdef ID_ILLEGAL_TRAP_EN
    , .illegal_ex(illegal_ex)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] inst;
    logic [29:0] pc;
    logic        valid;
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    int          cls;
    logic        wbk;
    logic        illegal;
  } ex_t;

  ex_t         m_ex;
  logic        m_stall_ld_ex;
  logic [31:0] m_rf [32];

  function automatic int cls_of(input logic [31:0] i);
    case (i[6:2])
      5'b01101: return C_LUI;
      5'b00101: return C_AUIPC;
      5'b11011: return C_JAL;
      5'b11001: return C_JALR;
      5'b11000: return C_BR;
      5'b00000: return C_LD;
      5'b01000: return C_ST;
      5'b00100: return C_ALUI;
      5'b01100: return C_ALU;
      5'b11100: return C_SYS;
      default:  return C_NONE;
    endcase
  endfunction

  // Immediates built arithmetically from the field weights of each format.
  function automatic logic [31:0] ref_imm(input logic [31:0] i, input int cls);
    int v;
    v = 0;
    if (cls == C_LD || cls == C_ALUI || cls == C_JALR || cls == C_SYS)
      v = (i[31] ? -2048 : 0) + int'(i[30:20]);
    else if (cls == C_ST)
      v = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
    else if (cls == C_BR)
      v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
          int'(i[11:8]) * 2;
    else if (cls == C_LUI || cls == C_AUIPC)
      v = int'(i & 32'hFFFF_F000);
    else if (cls == C_JAL)
      v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 +
          int'(i[30:21]) * 2;
    return 32'(v);
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wbk_en && wbk_rd_adr == a) return wbk_data;
    return m_rf[a];
  endfunction

  function automatic logic uses_rs1(input int c);
    return c inside {C_JALR, C_BR, C_LD, C_ST, C_ALUI, C_ALU};
  endfunction

  function automatic logic uses_rs2(input int c);
    return c inside {C_BR, C_ST, C_ALU};
  endfunction

  function automatic ex_t bubble_m(input logic [29:0] pc);
    ex_t b;
    b = '{inst: NOP, pc: pc, valid: 1'b0, rs1d: 32'd0, rs2d: 32'd0, imm: 32'd0,
          rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7b5: 1'b0, cls: C_NONE,
          wbk: 1'b0, illegal: 1'b0};
    return b;
  endfunction

  function automatic ex_t decode_m(input logic [31:0] i, input logic [29:0] pc);
    ex_t e;
    logic [6:0] f7;
    e.inst  = i;
    e.pc    = pc;
    e.valid = 1'b1;
    e.cls   = cls_of(i);
    e.rd    = i[11:7];
    e.rs1   = i[19:15];
    e.rs2   = i[24:20];
    e.rs1d  = rd_reg(e.rs1);
    e.rs2d  = rd_reg(e.rs2);
    e.imm   = ref_imm(i, e.cls);
    e.f3    = i[14:12];
    e.f7b5  = i[30];
    e.wbk   = (e.rd != 5'd0) &&
              (e.cls inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LD, C_ALUI, C_ALU});
    f7 = i[31:25];
    e.illegal = (i[1:0] != 2'b11) || (e.cls == C_NONE);
    if (e.cls == C_ALU && f7 != 7'h00 && f7 != 7'h20) e.illegal = 1'b1;
    if (e.cls == C_ALU && f7 == 7'h20 && e.f3 != 3'd0 && e.f3 != 3'd5) e.illegal = 1'b1;
    if (e.cls == C_ALUI && f7 == 7'h20 && e.f3 != 3'd5) e.illegal = 1'b1;
    return e;
  endfunction

  function automatic logic model_stall();
    logic hit;
    int   c;
    c   = cls_of(inst_id);
    hit = (uses_rs1(c) && inst_id[19:15] == m_ex.rd) ||
          (uses_rs2(c) && inst_id[24:20] == m_ex.rd);
    return m_ex.valid && m_ex.cls == C_LD && m_ex.rd != 5'd0 && hit && !jmp_flush_ex;
  endfunction

  function automatic logic [31:0] cmd_vec(input int c);
    if (c == C_NONE) return 32'd0;
    return 32'd1 << (9 - c);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("inst_ex", inst_ex, m_ex.inst);
    check("pc_ex", 32'(pc_ex), 32'(m_ex.pc));
    check("valid_ex", 32'(valid_ex), 32'(m_ex.valid));
    check("rs1_data_ex", rs1_data_ex, m_ex.rs1d);
    check("rs2_data_ex", rs2_data_ex, m_ex.rs2d);
    check("imm_ex", imm_ex, m_ex.imm);
    check("adr_ex", 32'({rd_adr_ex, rs1_adr_ex, rs2_adr_ex}),
          32'({m_ex.rd, m_ex.rs1, m_ex.rs2}));
    check("funct_ex", 32'({funct3_ex, funct7b5_ex}), 32'({m_ex.f3, m_ex.f7b5}));
    check("cmd_ex", 32'({cmd_lui_ex, cmd_auipc_ex, cmd_jal_ex, cmd_jalr_ex, cmd_br_ex,
                         cmd_ld_ex, cmd_st_ex, cmd_alui_ex, cmd_alu_ex, cmd_sys_ex}),
          cmd_vec(m_ex.cls));
    check("wbk_en_ex", 32'(wbk_en_ex), 32'(m_ex.wbk));
    check("stall_ld_ex", 32'(stall_ld_ex), 32'(m_stall_ld_ex));
`ifdef ID_ILLEGAL_TRAP_EN
    check("illegal_ex", 32'(illegal_ex), 32'(m_ex.illegal));
`endif
  endtask

  // Entered just after a rising edge with inputs already driven; returns
  // just after the next rising edge with the model advanced and compared.
  task automatic step();
    logic exp_stall;
    ex_t  nxt;
    @(negedge clk);
    exp_stall = model_stall();
    check("stall_ld", 32'(stall_ld), 32'(exp_stall));
    if (rst_pipe)
      nxt = bubble_m(pc_id);
    else if (stall)
      nxt = m_ex;
    else if (jmp_flush_ex || post_jump_cmd_cond || exp_stall)
      nxt = bubble_m(pc_id);
    else
      nxt = decode_m(inst_id, pc_id);
    m_stall_ld_ex = rst_pipe ? 1'b0 : exp_stall;
    if (wbk_en && wbk_rd_adr != 5'd0) m_rf[wbk_rd_adr] = wbk_data;
    m_ex = nxt;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    stall = 1'b0; rst_pipe = 1'b0; jmp_flush_ex = 1'b0; post_jump_cmd_cond = 1'b0;
    wbk_en = 1'b0; wbk_rd_adr = 5'd0; wbk_data = 32'd0;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [29:0] pc);
    inst_id = inst;
    pc_id   = pc;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [4:0]  opc_tab [10];
  logic [31:0] r;
  logic [2:0]  sel;

  initial begin
    opc_tab = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b11100};
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_ex          = bubble_m(30'd0);
    m_stall_ld_ex = 1'b0;
    idle();
    drive(NOP, 30'd0);
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_inst_ex", inst_ex, 32'h0000_0013);
    check("reset_stall_ld", 32'(stall_ld), 32'd0);
    rst_n = 1'b1;

    // addi x1,x0,5
    drive(32'h0050_0093, 30'h40);
    step();
    check("addi_imm", imm_ex, 32'd5);
    check("addi_alui", 32'(cmd_alui_ex), 32'd1);

    // Write-through from WB into a same-cycle read, then an x0 write
    wbk_en = 1'b1; wbk_rd_adr = 5'd2; wbk_data = 32'hDEAD_BEEF;
    drive(32'h0001_0193, 30'h41);
    step();
    check("bypass_rs1", rs1_data_ex, 32'hDEAD_BEEF);
    wbk_rd_adr = 5'd0; wbk_data = 32'h1234_5678;
    drive(32'h0000_0193, 30'h42);
    step();
    check("x0_reads_zero", rs1_data_ex, 32'd0);
    idle();
    drive(32'h0001_0213, 30'h43);   // addi x4,x2,0 reads the committed x2
    step();
    check("x2_committed", rs1_data_ex, 32'hDEAD_BEEF);

    // Load-use: lw x5,0(x1) followed by add x6,x5,x5
    drive(32'h0000_A283, 30'h50);
    step();
    drive(32'h0052_8333, 30'h51);
    #2;
    check("ld_use_stall", 32'(stall_ld), 32'd1);
    step();
    check("ld_use_bubble", 32'(valid_ex), 32'd0);
    check("ld_use_stall_ex", 32'(stall_ld_ex), 32'd1);
    #1;
    check("ld_use_released", 32'(stall_ld), 32'd0);
    step();
    check("ld_use_add_in_ex", 32'(cmd_alu_ex & valid_ex), 32'd1);
    check("ld_use_stall_ex_clr", 32'(stall_ld_ex), 32'd0);

    // Load to x0 never stalls
    drive(32'h0000_A003, 30'h60);
    step();
    drive(32'h0000_0333, 30'h61);
    #2;
    check("ld_x0_no_stall", 32'(stall_ld), 32'd0);
    step();

    // Flush: hazard suppressed by jump, then post-jump bubble
    drive(32'h0000_A283, 30'h70);
    step();
    drive(32'h0052_8333, 30'h71);
    jmp_flush_ex = 1'b1;
    #2;
    check("flush_masks_stall", 32'(stall_ld), 32'd0);
    step();
    check("flush_bubble", 32'({valid_ex, wbk_en_ex}), 32'd0);
    jmp_flush_ex = 1'b0; post_jump_cmd_cond = 1'b1;
    drive(32'h0050_0093, 30'h72);
    step();
    check("post_jump_bubble", 32'({valid_ex, wbk_en_ex}), 32'd0);
    post_jump_cmd_cond = 1'b0;

    // Global stall holds EX while a WB write to x7 lands
    drive(32'h0050_0093, 30'h80);
    step();
    stall = 1'b1;
    drive(32'h0052_8333, 30'h81);
    wbk_en = 1'b1; wbk_rd_adr = 5'd7; wbk_data = 32'hCAFE_0007;
    step();
    wbk_en = 1'b0;
    step();
    step();
    check("stall_hold_inst", inst_ex, 32'h0050_0093);
    stall = 1'b0;
    drive(32'h0003_8413, 30'h82);   // addi x8,x7,0
    step();
    check("stall_wb_landed", rs1_data_ex, 32'hCAFE_0007);
    stall = 1'b1; rst_pipe = 1'b1;
    step();
    check("rst_pipe_over_stall", 32'({valid_ex, inst_ex}), {1'b0, 32'h0000_0013});
    idle();

    // Immediate formats
    drive(32'hFE00_0EE3, 30'h90);
    step();
    check("b_imm", imm_ex, 32'hFFFF_FFFC);
    drive(32'h8000_00EF, 30'h91);
    step();
    check("j_imm", imm_ex, 32'hFFF0_0000);
`ifdef ID_ILLEGAL_TRAP_EN
    drive(32'h0000_0000, 30'h92);
    step();
    check("illegal_zero", 32'(illegal_ex), 32'd1);
`endif

    // Randomized traffic with small register indices to provoke hazards
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 10) < 10) r[6:2] = opc_tab[$urandom_range(0, 9)];
      r[1:0] = 2'b11;
`ifdef ID_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom);
`endif
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      if (sel < 3)      r[31:25] = 7'h00;
      else if (sel < 5) r[31:25] = 7'h20;
      drive(r, 30'($urandom));
      stall              = ($urandom_range(0, 9) == 0);
      rst_pipe           = ($urandom_range(0, 29) == 0);
      jmp_flush_ex       = ($urandom_range(0, 9) == 0);
      post_jump_cmd_cond = ($urandom_range(0, 9) == 0);
      wbk_en             = ($urandom_range(0, 1) == 1);
      wbk_rd_adr         = 5'($urandom_range(0, 3));
      wbk_data           = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
